// File: rtl/hit_acc_frame.sv
// Frame-based hit accumulator: popcounts a hit bus every accepted beat, accumulates
// the counts per frame and hands each closed frame total out on a valid/ready result port.
module hit_acc_frame #(
    parameter int LANES    = 4,
    parameter int CNT_W    = 8,
    parameter int SATURATE = 1,
    parameter int PIPE     = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             acc_clear_i,
    input  logic             acc_en_i,
    input  logic             acc_last_i,
    input  logic [LANES-1:0] hit_i,
    input  logic [CNT_W-1:0] thresh_i,
    output logic             acc_ready_o,
    output logic [CNT_W-1:0] candidate_o,
    output logic             sat_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [CNT_W-1:0] res_count_o,
    output logic             res_over_o,
    output logic             res_sat_o,
    output logic [1:0]       dbg_state_o
);

    localparam int PSUM_W = $clog2(LANES + 1);

    // Handshakes: a beat moves when acc_en_i & acc_ready_o (and no clear in that cycle);
    // a result moves when res_valid_o & res_ready_i. Both are sampled at the rising edge.
    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic              accept;
    logic [PSUM_W-1:0] psum;
    logic              add_valid;
    logic              add_last;
    logic [PSUM_W-1:0] add_sum;
    logic [CNT_W:0]    sum_w;
    logic              ovf;
    logic [CNT_W-1:0]  sum_fin;
    logic              close;

    assign acc_ready_o = (state_q == ST_ACC);
    assign res_valid_o = (state_q == ST_HOLD);
    assign dbg_state_o = state_q;
    assign accept      = acc_en_i & acc_ready_o & ~acc_clear_i;

    always_comb begin
        psum = '0;
        if (accept) begin
            for (int i = 0; i < LANES; i++) begin
                psum = psum + PSUM_W'(hit_i[i]);
            end
        end
    end

    generate
        if (PIPE != 0) begin : g_pipe
            logic              stg_valid_q;
            logic              stg_last_q;
            logic [PSUM_W-1:0] stg_sum_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    stg_valid_q <= 1'b0;
                    stg_last_q  <= 1'b0;
                    stg_sum_q   <= '0;
                end else if (acc_clear_i) begin
                    stg_valid_q <= 1'b0;
                    stg_last_q  <= 1'b0;
                    stg_sum_q   <= '0;
                end else begin
                    stg_valid_q <= accept;
                    stg_last_q  <= accept & acc_last_i;
                    stg_sum_q   <= psum;
                end
            end

            assign add_valid = stg_valid_q;
            assign add_last  = stg_last_q;
            assign add_sum   = stg_sum_q;
        end else begin : g_comb
            assign add_valid = accept;
            assign add_last  = accept & acc_last_i;
            assign add_sum   = psum;
        end
    endgenerate

    // The carry bit of the widened sum is the overflow flag for both arithmetic modes.
    assign sum_w   = {1'b0, candidate_o} + (CNT_W + 1)'(add_sum);
    assign ovf     = sum_w[CNT_W];
    assign sum_fin = (ovf && (SATURATE != 0)) ? {CNT_W{1'b1}} : sum_w[CNT_W-1:0];
    assign close   = add_valid & add_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            candidate_o <= '0;
            sat_o       <= 1'b0;
            res_count_o <= '0;
            res_over_o  <= 1'b0;
            res_sat_o   <= 1'b0;
        end else if (acc_clear_i) begin
            candidate_o <= '0;
            sat_o       <= 1'b0;
        end else if (close) begin
            res_count_o <= sum_fin;
            res_over_o  <= (sum_fin >= thresh_i);
            res_sat_o   <= sat_o | ovf;
            candidate_o <= '0;
            sat_o       <= 1'b0;
        end else if (add_valid) begin
            candidate_o <= sum_fin;
            sat_o       <= sat_o | ovf;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC: begin
                if (accept && acc_last_i) begin
                    state_d = (PIPE != 0) ? ST_DRAIN : ST_HOLD;
                end
            end
            ST_DRAIN: state_d = ST_HOLD;
            ST_HOLD: begin
                if (res_ready_i) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
        if (acc_clear_i) begin
            state_d = ST_ACC;
        end
    end

endmodule

// File: tb/tb_hit_acc_frame.sv
// Bench for hit_acc_frame: four configurations share one stimulus stream and are checked
// by directed scenarios and by a frame-level reference model under random traffic.
module tb_hit_acc_frame;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       acc_clear = 1'b0;
    logic       acc_en = 1'b0;
    logic       acc_last = 1'b0;
    logic [3:0] hit = 4'd0;
    logic [7:0] thresh = 8'd0;
    logic       res_ready = 1'b0;

    logic [3:0]      rdy, satv, rv, ro, rs;
    logic [3:0][7:0] cand, rc;
    logic [3:0][1:0] dbg;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Instance 0: PIPE=0 SAT W8; 1: PIPE=1 SAT W8; 2: PIPE=0 SAT W4; 3: PIPE=0 WRAP W4
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g >= 2) ? 4 : 8;
        logic [W-1:0] c_w, rc_w;
        hit_acc_frame #(
            .LANES(4), .CNT_W(W), .SATURATE((g == 3) ? 0 : 1), .PIPE((g == 1) ? 1 : 0)
        ) u_dut (
            .clk_i(clk), .rst_ni(rst_n), .acc_clear_i(acc_clear), .acc_en_i(acc_en),
            .acc_last_i(acc_last), .hit_i(hit), .thresh_i(thresh[W-1:0]),
            .acc_ready_o(rdy[g]), .candidate_o(c_w), .sat_o(satv[g]),
            .res_valid_o(rv[g]), .res_ready_i(res_ready), .res_count_o(rc_w),
            .res_over_o(ro[g]), .res_sat_o(rs[g]), .dbg_state_o(dbg[g])
        );
        assign cand[g] = 8'(c_w);
        assign rc[g]   = 8'(rc_w);
    end

    function automatic int cfg_w(int g);
        return (g >= 2) ? 4 : 8;
    endfunction
    function automatic bit cfg_pipe(int g);
        return g == 1;
    endfunction
    function automatic bit cfg_sat(int g);
        return g != 3;
    endfunction

    // Reference model: phase 0 accepting, 1 last beat still in the popcount stage, 2 result held.
    int m_total[4], m_sat[4], m_phase[4], m_pv[4], m_ps[4], m_pl[4], m_rc[4], m_ro[4], m_rs[4];

    always @(posedge clk or negedge rst_n) begin
        int mx, acc, ps, av, asum, al, s, r, ov;
        if (!rst_n) begin
            for (int g = 0; g < 4; g++) begin
                m_total[g] = 0; m_sat[g] = 0; m_phase[g] = 0; m_pv[g] = 0;
                m_ps[g] = 0; m_pl[g] = 0; m_rc[g] = 0; m_ro[g] = 0; m_rs[g] = 0;
            end
        end else begin
            for (int g = 0; g < 4; g++) begin
                mx  = (1 << cfg_w(g)) - 1;
                acc = (acc_en && m_phase[g] == 0 && !acc_clear) ? 1 : 0;
                ps  = acc ? $countones(hit) : 0;
                if (cfg_pipe(g)) begin
                    av = m_pv[g]; asum = m_ps[g]; al = m_pl[g];
                end else begin
                    av = acc; asum = ps; al = (acc != 0 && acc_last) ? 1 : 0;
                end
                if (acc_clear) begin
                    m_total[g] = 0; m_sat[g] = 0; m_phase[g] = 0;
                    m_pv[g] = 0; m_ps[g] = 0; m_pl[g] = 0;
                end else begin
                    m_pv[g] = acc; m_ps[g] = ps; m_pl[g] = (acc != 0 && acc_last) ? 1 : 0;
                    if (av != 0) begin
                        s  = m_total[g] + asum;
                        ov = (s > mx) ? 1 : 0;
                        r  = (ov == 0) ? s : (cfg_sat(g) ? mx : s - mx - 1);
                        if (al != 0) begin
                            m_rc[g] = r;
                            m_ro[g] = (r >= (int'(thresh) & mx)) ? 1 : 0;
                            m_rs[g] = m_sat[g] | ov;
                            m_total[g] = 0; m_sat[g] = 0;
                        end else begin
                            m_total[g] = r; m_sat[g] = m_sat[g] | ov;
                        end
                    end
                    if (m_phase[g] == 0) begin
                        if (acc != 0 && acc_last) m_phase[g] = cfg_pipe(g) ? 1 : 2;
                    end else if (m_phase[g] == 1) begin
                        m_phase[g] = 2;
                    end else if (res_ready) begin
                        m_phase[g] = 0;
                    end
                end
            end
        end
    end

    // Apply one cycle of inputs and return at the following falling edge.
    task automatic cycle(input bit clr, input bit en, input bit last, input logic [3:0] h,
                         input bit rr);
        acc_clear = clr; acc_en = en; acc_last = last; hit = h; res_ready = rr;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int g = 0; g < 4; g++) begin
            n_checks++; if (rdy[g] !== 1'b1) $display("FAIL reset_ready[%0d] got %b exp 1", g, rdy[g]); else n_pass++;
            n_checks++; if (cand[g] !== 8'd0) $display("FAIL reset_cand[%0d] got %0d exp 0", g, cand[g]); else n_pass++;
            n_checks++; if (rv[g] !== 1'b0) $display("FAIL reset_rvalid[%0d] got %b exp 0", g, rv[g]); else n_pass++;
            n_checks++; if ({satv[g], ro[g], rs[g], rc[g]} !== 11'd0)
                $display("FAIL reset_res[%0d] got %b exp 0", g, {satv[g], ro[g], rs[g], rc[g]}); else n_pass++;
            n_checks++; if (dbg[g] !== 2'd0) $display("FAIL reset_state[%0d] got %0d exp 0", g, dbg[g]); else n_pass++;
        end
    endtask

    task automatic test_frame();
        thresh = 8'd0;
        cycle(1, 0, 0, 4'b0000, 1);
        cycle(0, 1, 0, 4'b1011, 1);
        n_checks++; if (cand[0] !== 8'd3) $display("FAIL frame_cand1 got %0d exp 3", cand[0]); else n_pass++;
        cycle(0, 1, 0, 4'b1011, 1);
        n_checks++; if (cand[0] !== 8'd6) $display("FAIL frame_cand2 got %0d exp 6", cand[0]); else n_pass++;
        cycle(0, 1, 1, 4'b1011, 1);
        n_checks++; if (rv[0] !== 1'b1) $display("FAIL frame_rvalid got %b exp 1", rv[0]); else n_pass++;
        n_checks++; if (rc[0] !== 8'd9) $display("FAIL frame_count got %0d exp 9", rc[0]); else n_pass++;
        n_checks++; if (cand[0] !== 8'd0) $display("FAIL frame_cand_clr got %0d exp 0", cand[0]); else n_pass++;
        cycle(0, 0, 0, 4'b0000, 1);
        n_checks++; if (rv[0] !== 1'b0) $display("FAIL frame_rvalid_drop got %b exp 0", rv[0]); else n_pass++;
        n_checks++; if (rdy[0] !== 1'b1) $display("FAIL frame_ready got %b exp 1", rdy[0]); else n_pass++;
    endtask

    task automatic test_saturate();
        cycle(1, 0, 0, 4'b0000, 1);
        repeat (5) cycle(0, 1, 0, 4'b1111, 1);
        n_checks++; if (cand[2] !== 8'd15) $display("FAIL sat_cand got %0d exp 15", cand[2]); else n_pass++;
        n_checks++; if (satv[2] !== 1'b1) $display("FAIL sat_flag got %b exp 1", satv[2]); else n_pass++;
        n_checks++; if (cand[3] !== 8'd4) $display("FAIL wrap_cand got %0d exp 4", cand[3]); else n_pass++;
        n_checks++; if (satv[3] !== 1'b1) $display("FAIL wrap_flag got %b exp 1", satv[3]); else n_pass++;
        n_checks++; if ({satv[0], cand[0]} !== {1'b0, 8'd20}) $display("FAIL wide_cand got %0d exp 20", cand[0]); else n_pass++;
        n_checks++; if (cand[1] !== 8'd16) $display("FAIL pipe_lag_cand got %0d exp 16", cand[1]); else n_pass++;
        cycle(0, 1, 1, 4'b0000, 1);
        n_checks++; if ({rv[2], rc[2], rs[2]} !== {1'b1, 8'd15, 1'b1}) $display("FAIL sat_close got %b exp %b", {rv[2], rc[2], rs[2]}, {1'b1, 8'd15, 1'b1}); else n_pass++;
        n_checks++; if ({rv[3], rc[3], rs[3]} !== {1'b1, 8'd4, 1'b1}) $display("FAIL wrap_close got %b exp %b", {rv[3], rc[3], rs[3]}, {1'b1, 8'd4, 1'b1}); else n_pass++;
        n_checks++; if ({satv[2], cand[2]} !== 9'd0) $display("FAIL sat_reopen got %b exp 0", {satv[2], cand[2]}); else n_pass++;
    endtask

    task automatic test_hold();
        cycle(1, 0, 0, 4'b0000, 1);
        cycle(0, 1, 1, 4'b0011, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 4'b1111, 0);
            n_checks++; if ({rdy[0], rv[0]} !== 2'b01) $display("FAIL hold_hs[%0d] got %b exp 01", i, {rdy[0], rv[0]}); else n_pass++;
            n_checks++; if (cand[0] !== 8'd0) $display("FAIL hold_cand[%0d] got %0d exp 0", i, cand[0]); else n_pass++;
            n_checks++; if (rc[0] !== 8'd2) $display("FAIL hold_count[%0d] got %0d exp 2", i, rc[0]); else n_pass++;
        end
        cycle(0, 0, 0, 4'b0000, 1);
        n_checks++; if ({rdy[0], rv[0]} !== 2'b10) $display("FAIL hold_release got %b exp 10", {rdy[0], rv[0]}); else n_pass++;
    endtask

    task automatic test_clear();
        cycle(1, 0, 0, 4'b0000, 1);
        cycle(0, 1, 0, 4'b1111, 1);
        cycle(0, 1, 0, 4'b0111, 1);
        n_checks++; if (cand[0] !== 8'd7) $display("FAIL clear_pre got %0d exp 7", cand[0]); else n_pass++;
        cycle(1, 1, 0, 4'b1111, 1);
        n_checks++; if (cand[0] !== 8'd0) $display("FAIL clear_cand got %0d exp 0", cand[0]); else n_pass++;
        cycle(0, 0, 0, 4'b0000, 1);
        n_checks++; if (cand[0] !== 8'd0) $display("FAIL clear_beat_lost got %0d exp 0", cand[0]); else n_pass++;
        n_checks++; if (cand[1] !== 8'd0) $display("FAIL clear_pipe_flush got %0d exp 0", cand[1]); else n_pass++;
        cycle(0, 1, 1, 4'b0001, 0);
        n_checks++; if (rv[0] !== 1'b1) $display("FAIL clear_hold_setup got %b exp 1", rv[0]); else n_pass++;
        cycle(1, 0, 0, 4'b0000, 0);
        n_checks++; if ({rdy[0], rv[0]} !== 2'b10) $display("FAIL clear_in_hold got %b exp 10", {rdy[0], rv[0]}); else n_pass++;
        n_checks++; if (rc[0] !== 8'd1) $display("FAIL clear_res_kept got %0d exp 1", rc[0]); else n_pass++;
    endtask

    task automatic test_pipe();
        cycle(1, 0, 0, 4'b0000, 1);
        cycle(0, 1, 0, 4'b0011, 1);
        n_checks++; if (cand[1] !== 8'd0) $display("FAIL pipe_stage got %0d exp 0", cand[1]); else n_pass++;
        cycle(0, 0, 0, 4'b0000, 1);
        n_checks++; if (cand[1] !== 8'd2) $display("FAIL pipe_add got %0d exp 2", cand[1]); else n_pass++;
        cycle(0, 1, 1, 4'b0001, 0);
        n_checks++; if ({rdy[1], rv[1], dbg[1]} !== 4'b0001) $display("FAIL pipe_drain got %b exp 0001", {rdy[1], rv[1], dbg[1]}); else n_pass++;
        cycle(0, 1, 0, 4'b1111, 0);
        n_checks++; if ({rdy[1], rv[1]} !== 2'b01) $display("FAIL pipe_hold got %b exp 01", {rdy[1], rv[1]}); else n_pass++;
        n_checks++; if ({rc[1], cand[1]} !== {8'd3, 8'd0}) $display("FAIL pipe_result got %0d/%0d exp 3/0", rc[1], cand[1]); else n_pass++;
        cycle(0, 0, 0, 4'b0000, 1);
        n_checks++; if ({rdy[1], rv[1]} !== 2'b10) $display("FAIL pipe_release got %b exp 10", {rdy[1], rv[1]}); else n_pass++;
    endtask

    task automatic test_thresh();
        thresh = 8'd9;
        cycle(1, 0, 0, 4'b0000, 1);
        cycle(0, 1, 0, 4'b1111, 1);
        cycle(0, 1, 0, 4'b1111, 1);
        cycle(0, 1, 1, 4'b0001, 1);
        n_checks++; if ({rc[0], ro[0]} !== {8'd9, 1'b1}) $display("FAIL thresh_eq got %0d/%b exp 9/1", rc[0], ro[0]); else n_pass++;
        n_checks++; if ({rc[2], ro[2]} !== {8'd9, 1'b1}) $display("FAIL thresh_eq_w4 got %0d/%b exp 9/1", rc[2], ro[2]); else n_pass++;
        cycle(0, 0, 0, 4'b0000, 1);
        cycle(0, 1, 0, 4'b1111, 1);
        cycle(0, 1, 0, 4'b1111, 1);
        cycle(0, 1, 1, 4'b0000, 1);
        n_checks++; if ({rc[0], ro[0]} !== {8'd8, 1'b0}) $display("FAIL thresh_below got %0d/%b exp 8/0", rc[0], ro[0]); else n_pass++;
    endtask

    task automatic test_async_reset();
        cycle(1, 0, 0, 4'b0000, 1);
        cycle(0, 1, 0, 4'b1111, 1);
        n_checks++; if (cand[0] !== 8'd4) $display("FAIL areset_pre got %0d exp 4", cand[0]); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            n_checks++; if ({rdy[g], rv[g], satv[g], ro[g], rs[g], cand[g], rc[g]} !== {1'b1, 20'd0})
                $display("FAIL areset[%0d] got %b exp %b", g, {rdy[g], rv[g], satv[g], ro[g], rs[g], cand[g], rc[g]}, {1'b1, 20'd0});
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            thresh = 8'($urandom_range(0, 20));
            cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 3) == 0), 4'($urandom), ($urandom_range(0, 1) == 1));
            for (int g = 0; g < 4; g++) begin
                n_checks++; if (rdy[g] !== (m_phase[g] == 0)) $display("FAIL rand_ready[%0d] cyc %0d got %b exp %b", g, c, rdy[g], m_phase[g] == 0); else n_pass++;
                n_checks++; if (rv[g] !== (m_phase[g] == 2)) $display("FAIL rand_rvalid[%0d] cyc %0d got %b exp %b", g, c, rv[g], m_phase[g] == 2); else n_pass++;
                n_checks++; if (cand[g] !== 8'(m_total[g])) $display("FAIL rand_cand[%0d] cyc %0d got %0d exp %0d", g, c, cand[g], m_total[g]); else n_pass++;
                n_checks++; if (satv[g] !== (m_sat[g] != 0)) $display("FAIL rand_sat[%0d] cyc %0d got %b exp %0d", g, c, satv[g], m_sat[g]); else n_pass++;
                n_checks++; if (rc[g] !== 8'(m_rc[g])) $display("FAIL rand_count[%0d] cyc %0d got %0d exp %0d", g, c, rc[g], m_rc[g]); else n_pass++;
                n_checks++; if ({ro[g], rs[g]} !== {m_ro[g] != 0, m_rs[g] != 0}) $display("FAIL rand_flags[%0d] cyc %0d got %b exp %0d%0d", g, c, {ro[g], rs[g]}, m_ro[g], m_rs[g]); else n_pass++;
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_frame();
        test_saturate();
        test_hold();
        test_clear();
        test_pipe();
        test_thresh();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
